cop0_exception_unit: RTL and testbench
======================================

Name: cop0_exception_unit

Overview:
- MIPS Coprocessor 0 for the 5-stage pipeline: holds the Status (reg 12), Cause (reg 13) and EPC (reg 14) registers.
- Detects and prioritises overflow, reserved-instruction and external-interrupt exceptions, and drives the pipeline flush plus the handler and return addresses.
- Serves MTC0 writes and MFC0 reads from the decode stage.
- Sits beside the hazard unit; its outputs feed fetch PC selection and the pipeline-register flush gating.

Parameters:
- HANDLER_ADDR, 32'h0000_0100, fetch address of the exception handler.
- STATUS_RST, 32'h0000_0000, reset value of Status.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_arithmetic_overflow  in  1  ALU overflow, execute stage.
- i_unknown_command  in  1  undefined opcode, decode stage.
- i_unknown_func  in  1  undefined R-type funct, decode stage.
- i_external_interrupt  in  1  level-sensitive hardware interrupt.
- i_data  in  32  MTC0 write data.
- i_address  in  5  CP0 register number (instr[15:11]).
- i_pc_to_epc_from_execute  in  32  PC of instruction in EX.
- i_pc_to_epc_from_decode  in  32  PC of instruction in ID.
- i_pc_to_epc_from_fetch  in  32  PC of instruction in IF.
- i_mtc0  in  1  MTC0 in decode.
- i_eret  in  1  ERET in decode.
- o_epc_to_pc  out  32  current EPC, the ERET target.
- o_exception  out  1  take-exception/flush, combinational.
- o_handler_address  out  32  constant HANDLER_ADDR.
- o_data  out  32  MFC0 read data.

Behaviour:
- Register fields:
  - Status: bit0 IE, bit1 EXL, bits[15:8] IM; other bits read 0.
  - Cause: bits[6:2] ExcCode, bits[15:8] IP. IP2 is bit10 and is hardware-driven; IP[1:0] (bits 9:8) are software-writable. Other bits read 0.
  - EPC: full 32 bits.
- Reset (async, i_rst=1): Status=STATUS_RST, Cause=0, EPC=0, o_exception=0, o_data reflects the reset registers.
- Cause.IP2 samples i_external_interrupt every clock, giving 1 cycle of latency.
- Exception request priority (highest first):
  1. i_arithmetic_overflow: ExcCode 12, EPC source = execute PC.
  2. i_unknown_command or i_unknown_func: ExcCode 10, EPC source = decode PC.
  3. Interrupt: IE & IP2 & IM2 (bit10), ExcCode 0, EPC source = fetch PC.
- o_exception = (any request) & !EXL, combinational in the same cycle as the request.
- On the rising edge with o_exception=1: EPC <= selected PC, Cause.ExcCode <= code, Status.EXL <= 1.
- While EXL=1, every request is masked: no flush and no register update.
- i_eret on an edge: Status.EXL <= 0. o_epc_to_pc always equals EPC.
- i_mtc0 on an edge: the register selected by i_address is written with i_data.
  - Cause: only bits 9:8 are written.
  - Status: only IE, EXL and IM are written.
  - Writes to unimplemented addresses are ignored.
- o_data = selected register (combinational); unimplemented addresses return 0.
- Simultaneous events in one cycle:
  - Exception and mtc0: exception wins; the mtc0 write is dropped.
  - Exception and eret: exception wins; EXL stays 1.
  - mtc0 to Status and eret: the mtc0 value is applied, then EXL is cleared.
- Reset asserted mid-exception returns all state to reset values immediately; no pending exception survives.

Optional Feature:
- Macro COP0_TIMER_EN.
- Defined:
  - Adds Count (reg 9) and Compare (reg 11). Count increments every clock and wraps at 2^32.
  - When Count == Compare, Cause.IP7 (bit15) is set.
  - Timer interrupt = IE & IP7 & IM7, same priority as the external interrupt, ExcCode 0, EPC = fetch PC.
  - An MTC0 write to Compare clears IP7.
  - Both registers are MTC0/MFC0 accessible and reset to 0.
- Undefined: regs 9 and 11 read 0, writes are ignored, IP7 is always 0.

Test Plan:
- Reset, then MFC0 of 12/13/14 -> o_data 0, o_exception 0, o_handler_address 32'h100.
- Overflow=1 with execute PC 0x40 and decode PC 0x44 -> o_exception=1 same cycle. Next edge: EPC=0x40, Cause=0x30, EXL=1. A second overflow while EXL=1 -> o_exception=0.
- Overflow and unknown_command together (PCs 0x20 / 0x24) -> EPC=0x20, ExcCode 12.
- MTC0 Status=0x401, then hold external_interrupt=1 with fetch PC 0x88 -> o_exception rises one cycle after the interrupt, EPC=0x88, ExcCode 0. ERET -> EXL=0, o_epc_to_pc=0x88.
- MTC0 Cause=0xFFFFFFFF -> MFC0 Cause returns 0x300 (with the interrupt low). Unknown_func and mtc0 in the same cycle -> write dropped, ExcCode 10.
- COP0_TIMER_EN: MTC0 Compare=5, Status=0x8001 -> exception taken after Count reaches 5; MTC0 Compare clears IP7.

Source files
------------

// File: rtl/cop0_exception_unit.sv
// MIPS CP0: Status/Cause/EPC registers, exception prioritisation and MTC0/MFC0 access.
// Optional Count/Compare timer interrupt enabled by defining COP0_TIMER_EN.
module cop0_exception_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
  parameter logic [31:0] STATUS_RST   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_arithmetic_overflow,
  input  logic        i_unknown_command,
  input  logic        i_unknown_func,
  input  logic        i_external_interrupt,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_address,
  input  logic [31:0] i_pc_to_epc_from_execute,
  input  logic [31:0] i_pc_to_epc_from_decode,
  input  logic [31:0] i_pc_to_epc_from_fetch,
  input  logic        i_mtc0,
  input  logic        i_eret,
  output logic [31:0] o_epc_to_pc,
  output logic        o_exception,
  output logic [31:0] o_handler_address,
  output logic [31:0] o_data
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [4:0]  cause_exc;
  logic [1:0]  cause_ip_sw;
  logic        cause_ip2;
  logic        cause_ip7;
  logic [31:0] epc;

  logic [31:0] status_word;
  logic [31:0] cause_word;

  logic        exc_req;
  logic        exc_take;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        int_req;

  assign status_word = {16'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_word  = {16'b0, cause_ip7, 4'b0, cause_ip2, cause_ip_sw, 1'b0, cause_exc, 2'b0};

  assign int_req = status_ie & ((cause_ip2 & status_im[2]) | (cause_ip7 & status_im[7]));

  always_comb begin
    exc_req  = 1'b0;
    exc_code = EXC_INT;
    exc_pc   = '0;
    if (i_arithmetic_overflow) begin
      exc_req  = 1'b1;
      exc_code = EXC_OV;
      exc_pc   = i_pc_to_epc_from_execute;
    end else if (i_unknown_command || i_unknown_func) begin
      exc_req  = 1'b1;
      exc_code = EXC_RI;
      exc_pc   = i_pc_to_epc_from_decode;
    end else if (int_req) begin
      exc_req  = 1'b1;
      exc_code = EXC_INT;
      exc_pc   = i_pc_to_epc_from_fetch;
    end
  end

  assign exc_take          = exc_req & ~status_exl;
  // Reset gates the flush so a request held across reset cannot leak out.
  assign o_exception       = exc_take & ~i_rst;
  assign o_epc_to_pc       = epc;
  assign o_handler_address = HANDLER_ADDR;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      status_ie   <= STATUS_RST[0];
      status_exl  <= STATUS_RST[1];
      status_im   <= STATUS_RST[15:8];
      cause_exc   <= '0;
      cause_ip_sw <= '0;
      cause_ip2   <= 1'b0;
      epc         <= '0;
    end else begin
      cause_ip2 <= i_external_interrupt;
      if (exc_take) begin
        epc        <= exc_pc;
        cause_exc  <= exc_code;
        status_exl <= 1'b1;
      end else begin
        if (i_mtc0) begin
          case (i_address)
            ADDR_STATUS: begin
              status_ie  <= i_data[0];
              status_exl <= i_data[1];
              status_im  <= i_data[15:8];
            end
            ADDR_CAUSE: cause_ip_sw <= i_data[9:8];
            ADDR_EPC:   epc         <= i_data;
            default: ;
          endcase
        end
        // Later assignment wins, so an ERET alongside an MTC0 to Status still clears EXL.
        if (i_eret) status_exl <= 1'b0;
      end
    end
  end

`ifdef COP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        wr_ok;

  assign wr_ok = i_mtc0 & ~exc_take;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count     <= '0;
      compare   <= '0;
      cause_ip7 <= 1'b0;
    end else begin
      count <= count + 32'd1;
      if (count == compare) cause_ip7 <= 1'b1;
      if (wr_ok && i_address == ADDR_COUNT) count <= i_data;
      if (wr_ok && i_address == ADDR_COMPARE) begin
        compare   <= i_data;
        cause_ip7 <= 1'b0;
      end
    end
  end

  always_comb begin
    o_data = '0;
    case (i_address)
      ADDR_COUNT:   o_data = count;
      ADDR_COMPARE: o_data = compare;
      ADDR_STATUS:  o_data = status_word;
      ADDR_CAUSE:   o_data = cause_word;
      ADDR_EPC:     o_data = epc;
      default:      o_data = '0;
    endcase
  end
`else
  assign cause_ip7 = 1'b0;

  always_comb begin
    o_data = '0;
    case (i_address)
      ADDR_STATUS: o_data = status_word;
      ADDR_CAUSE:  o_data = cause_word;
      ADDR_EPC:    o_data = epc;
      default:     o_data = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_cop0_exception_unit.sv
// Directed self-checking bench for cop0_exception_unit (timer section runs when COP0_TIMER_EN is defined).
module tb_cop0_exception_unit;

  logic        clk;
  logic        rst;
  logic        ovf;
  logic        unk_cmd;
  logic        unk_func;
  logic        ext_int;
  logic [31:0] wdata;
  logic [4:0]  addr;
  logic [31:0] pc_ex;
  logic [31:0] pc_id;
  logic [31:0] pc_if;
  logic        mtc0;
  logic        eret;
  logic [31:0] epc_to_pc;
  logic        exception;
  logic [31:0] handler;
  logic [31:0] rdata;

  int unsigned checks;
  int unsigned errors;

  cop0_exception_unit #(
    .HANDLER_ADDR(32'h0000_0100),
    .STATUS_RST  (32'h0000_0000)
  ) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_arithmetic_overflow   (ovf),
    .i_unknown_command       (unk_cmd),
    .i_unknown_func          (unk_func),
    .i_external_interrupt    (ext_int),
    .i_data                  (wdata),
    .i_address               (addr),
    .i_pc_to_epc_from_execute(pc_ex),
    .i_pc_to_epc_from_decode (pc_id),
    .i_pc_to_epc_from_fetch  (pc_if),
    .i_mtc0                  (mtc0),
    .i_eret                  (eret),
    .o_epc_to_pc             (epc_to_pc),
    .o_exception             (exception),
    .o_handler_address       (handler),
    .o_data                  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_eq(tag, rdata, exp);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    mtc0 = 1'b1; addr = a; wdata = d;
    tick();
    mtc0 = 1'b0; wdata = '0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; ovf = 0; unk_cmd = 0; unk_func = 0; ext_int = 0;
    wdata = '0; addr = '0; pc_ex = '0; pc_id = '0; pc_if = '0; mtc0 = 0; eret = 0;
    tick(); tick();
    read_reg("rst_status", 5'd12, 32'h0);
    read_reg("rst_cause", 5'd13, 32'h0);
    read_reg("rst_epc", 5'd14, 32'h0);
    check_eq("rst_exc", {31'b0, exception}, 32'h0);
    check_eq("handler", handler, 32'h100);
    rst = 1'b0;
    tick();

    // Overflow, then a second overflow masked by EXL
    pc_ex = 32'h40; pc_id = 32'h44; ovf = 1'b1;
    #1 check_eq("ovf_exc", {31'b0, exception}, 32'h1);
    tick();
    check_eq("ovf_masked", {31'b0, exception}, 32'h0);
    check_eq("ovf_epc", epc_to_pc, 32'h40);
    read_reg("ovf_cause", 5'd13, 32'h30);
    read_reg("ovf_status", 5'd12, 32'h2);
    tick();
    ovf = 1'b0;
    check_eq("ovf_epc_hold", epc_to_pc, 32'h40);
    do_eret();
    read_reg("eret_status", 5'd12, 32'h0);

    // Overflow beats unknown_command
    pc_ex = 32'h20; pc_id = 32'h24; ovf = 1'b1; unk_cmd = 1'b1;
    tick();
    ovf = 1'b0; unk_cmd = 1'b0;
    check_eq("prio_epc", epc_to_pc, 32'h20);
    read_reg("prio_cause", 5'd13, 32'h30);
    do_eret();

    // External interrupt with one cycle of IP2 latency
    write_reg(5'd12, 32'h401);
    read_reg("st_401", 5'd12, 32'h401);
    pc_if = 32'h88; ext_int = 1'b1;
    #1 check_eq("int_lat", {31'b0, exception}, 32'h0);
    tick();
    check_eq("int_exc", {31'b0, exception}, 32'h1);
    tick();
    ext_int = 1'b0;
    check_eq("int_epc", epc_to_pc, 32'h88);
    read_reg("int_cause", 5'd13, 32'h400);
    read_reg("int_status", 5'd12, 32'h403);
    tick();
    read_reg("ip2_clear", 5'd13, 32'h0);
    do_eret();
    read_reg("int_eret_st", 5'd12, 32'h401);
    check_eq("eret_target", epc_to_pc, 32'h88);

    // Cause write mask, then exception dropping a simultaneous mtc0
    write_reg(5'd13, 32'hFFFF_FFFF);
    read_reg("cause_mask", 5'd13, 32'h300);
    pc_id = 32'h60; unk_func = 1'b1;
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0;
    #1 check_eq("ri_exc", {31'b0, exception}, 32'h1);
    tick();
    mtc0 = 1'b0; unk_func = 1'b0;
    read_reg("ri_cause", 5'd13, 32'h328);
    read_reg("ri_status", 5'd12, 32'h403);
    check_eq("ri_epc", epc_to_pc, 32'h60);

    // Exception and ERET together: EXL stays set
    do_eret();
    read_reg("eret2_st", 5'd12, 32'h401);
    ovf = 1'b1; eret = 1'b1;
    tick();
    ovf = 1'b0; eret = 1'b0;
    read_reg("exc_eret_st", 5'd12, 32'h403);
    read_reg("exc_eret_cause", 5'd13, 32'h330);
    check_eq("exc_eret_epc", epc_to_pc, 32'h20);

    // MTC0 Status with ERET: write applies, then EXL clears
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0000_0403; eret = 1'b1;
    tick();
    mtc0 = 1'b0; eret = 1'b0;
    read_reg("mtc0_eret_st", 5'd12, 32'h401);

    // Unimplemented register
    write_reg(5'd3, 32'hDEAD_BEEF);
    read_reg("unimpl_rd", 5'd3, 32'h0);
    read_reg("unimpl_cause", 5'd13, 32'h330);
`ifndef COP0_TIMER_EN
    write_reg(5'd11, 32'h5);
    read_reg("no_compare", 5'd11, 32'h0);
`endif

    // Reset in the middle of a request
    pc_ex = 32'h90; ovf = 1'b1;
    #1 check_eq("pre_rst_exc", {31'b0, exception}, 32'h1);
    rst = 1'b1;
    #1 check_eq("rst_mid_exc", {31'b0, exception}, 32'h0);
    check_eq("rst_mid_epc", epc_to_pc, 32'h0);
    read_reg("rst_mid_st", 5'd12, 32'h0);
    read_reg("rst_mid_cause", 5'd13, 32'h0);
    ovf = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_exc", {31'b0, exception}, 32'h0);

`ifdef COP0_TIMER_EN
    begin
      bit seen;
      seen = 1'b0;
      write_reg(5'd11, 32'h5);
      read_reg("cmp_rd", 5'd11, 32'h5);
      write_reg(5'd12, 32'h8001);
      for (int i = 0; i < 20 && !seen; i++) begin
        if (exception) seen = 1'b1;
        else tick();
      end
      check_eq("tmr_exc", {31'b0, seen}, 32'h1);
      tick();
      read_reg("tmr_cause", 5'd13, 32'h8000);
      read_reg("tmr_st", 5'd12, 32'h8003);
      write_reg(5'd11, 32'h1000);
      read_reg("tmr_ip7_clr", 5'd13, 32'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
